rotate_block_coord_gen: RTL

//  Upstream stage of the DDR3 block-address calculator. Scans the output (rotated) frame block by block in raster order.

---
 rtl/rotate_block_coord_gen_if.sv | 19 +
 rtl/rotate_block_coord_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rotate_block_coord_gen_if.sv
// rotate_block_coord_gen_if: scan control, rotation coefficients and coordinate-FIFO write bus
interface rotate_block_coord_gen_if;
   logic               start;
   logic signed [15:0] cos_q14;
   logic signed [15:0] sin_q14;
   logic               fifo_wr_full;
   logic               wr_fifo_en;
   logic [22:0]        fifo_wr_data;
   logic               busy;
   logic               frame_done;
   modport master (
      input  start, cos_q14, sin_q14, fifo_wr_full,
      output wr_fifo_en, fifo_wr_data, busy, frame_done
   );
   modport slave (
      output start, cos_q14, sin_q14, fifo_wr_full,
      input  wr_fifo_en, fifo_wr_data, busy, frame_done
   );
endinterface

// File: rtl/rotate_block_coord_gen.sv
// rotate_block_coord_gen: raster-scans output blocks, inverse-rotates each about the centre, pushes source coords
module rotate_block_coord_gen #(
   parameter logic [10:0] BLK_W = 11'd480,
   parameter logic [10:0] BLK_H = 11'd270,
   parameter logic [10:0] CX    = 11'd240,
   parameter logic [10:0] CY    = 11'd135
) (
   input logic clk,
   input logic rst,
   rotate_block_coord_gen_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_DIFF, S_MULT, S_SUM, S_CHECK, S_WR, S_DONE} state_t;
   localparam logic signed [11:0] CX12 = {1'b0, CX};
   localparam logic signed [11:0] CY12 = {1'b0, CY};
   localparam logic signed [13:0] CX14 = {3'b0, CX};
   localparam logic signed [13:0] CY14 = {3'b0, CY};
   localparam logic signed [13:0] W14  = {3'b0, BLK_W};
   localparam logic signed [13:0] H14  = {3'b0, BLK_H};
   state_t             state_q, state_d;
   logic [10:0]        ox_q, ox_d, oy_q, oy_d;
   logic signed [15:0] cos_q, cos_d, sin_q, sin_d;
   logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
   logic signed [27:0] p_xc_q, p_xc_d, p_ys_q, p_ys_d, p_xs_q, p_xs_d, p_yc_q, p_yc_d;
   logic signed [13:0] sx_q, sx_d, sy_q, sy_d;
   logic [22:0]        data_q, data_d;
   logic signed [28:0] rx, ry;
   logic               oor, last_col, last_blk;
   // Rounded rotation sums: adding half an LSB before the arithmetic shift rounds half up
   assign rx = 29'(p_xc_q) + 29'(p_ys_q) + 29'sd8192;
   assign ry = 29'(p_yc_q) - 29'(p_xs_q) + 29'sd8192;
   assign oor = sx_q[13] || sx_q >= W14 || sy_q[13] || sy_q >= H14;
   assign last_col = ox_q == BLK_W - 11'd1;
   assign last_blk = last_col && oy_q == BLK_H - 11'd1;
   assign bus.wr_fifo_en   = state_q == S_WR && !bus.fifo_wr_full;
   assign bus.fifo_wr_data = data_q;
   assign bus.busy         = state_q != S_IDLE && state_q != S_DONE;
   assign bus.frame_done   = state_q == S_DONE;
   // Next-state logic: one pipeline step per state, each block takes five cycles
   always_comb begin
      state_d = state_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      p_xc_d  = p_xc_q;
      p_ys_d  = p_ys_q;
      p_xs_d  = p_xs_q;
      p_yc_d  = p_yc_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            cos_d   = bus.cos_q14;
            sin_d   = bus.sin_q14;
            ox_d    = '0;
            oy_d    = '0;
            state_d = S_DIFF;
         end
         S_DIFF: begin
            dx_d    = $signed({1'b0, ox_q}) - CX12;
            dy_d    = $signed({1'b0, oy_q}) - CY12;
            state_d = S_MULT;
         end
         S_MULT: begin
            p_xc_d  = 28'(dx_q) * 28'(cos_q);
            p_ys_d  = 28'(dy_q) * 28'(sin_q);
            p_xs_d  = 28'(dx_q) * 28'(sin_q);
            p_yc_d  = 28'(dy_q) * 28'(cos_q);
            state_d = S_SUM;
         end
         S_SUM: begin
            sx_d    = 14'(rx >>> 14) + CX14;
            sy_d    = 14'(ry >>> 14) + CY14;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            data_d  = oor ? {1'b1, 22'd0} : {1'b0, sx_q[10:0], sy_q[10:0]};
            state_d = S_WR;
         end
         S_WR: if (!bus.fifo_wr_full) begin
            ox_d    = last_col ? 11'd0 : ox_q + 11'd1;
            oy_d    = last_col ? oy_q + 11'd1 : oy_q;
            state_d = last_blk ? S_DONE : S_DIFF;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // State and datapath registers; reset aborts any scan in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ox_q    <= '0;
         oy_q    <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         p_xc_q  <= '0;
         p_ys_q  <= '0;
         p_xs_q  <= '0;
         p_yc_q  <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         p_xc_q  <= p_xc_d;
         p_ys_q  <= p_ys_d;
         p_xs_q  <= p_xs_d;
         p_yc_q  <= p_yc_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         data_q  <= data_d;
      end
   end
endmodule
